// File: rtl/chacha_key_assembler.sv
// chacha_key_assembler: gathers WORDS random words into a ChaCha20 key, handed off via valid/ack.
// Define CHACHA_KEY_DEDUP_EN to drop accepted words that repeat the last stored word.
module chacha_key_assembler #(
  parameter int N     = 32,
  parameter int WORDS = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [N-1:0]           i_rand_word,
  input  logic                   i_rand_ready,
  input  logic                   i_key_ack,
  output logic [WORDS*N-1:0]     o_key_out,
  output logic                   o_key_valid,
  output logic [$clog2(WORDS):0] o_word_cnt,
  output logic [7:0]             o_drop_cnt,
  output logic                   o_stuck_err
);
  localparam int CW = $clog2(WORDS) + 1;
  typedef enum logic {COLLECT, HOLD} state_t;
  state_t r_state, w_next;
  logic r_ready_q;
  logic [WORDS*N-1:0] r_shadow, w_merged;
  logic w_accept, w_dup, w_store, w_done, w_ack;
  logic [CW-1:0] w_idx;
  assign w_accept = i_rand_ready & ~r_ready_q;
  assign w_ack    = (r_state == HOLD) & o_key_valid & i_key_ack;
  // an accept that coincides with the ack in HOLD becomes word 0 of the next key
  assign w_idx    = (r_state == HOLD) ? '0 : o_word_cnt;
  assign w_store  = w_accept & ~w_dup & ((r_state == COLLECT) | w_ack);
  assign w_done   = w_store & (w_idx == CW'(WORDS - 1));
  assign w_next   = w_done ? HOLD : (w_ack ? COLLECT : r_state);
`ifdef CHACHA_KEY_DEDUP_EN
  logic [N-1:0] r_last;
  logic         r_have_last;
  assign w_dup = (r_state == COLLECT) & r_have_last & (i_rand_word == r_last);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_last      <= '0;
      r_have_last <= 1'b0;
      o_stuck_err <= 1'b0;
    end else begin
      if (w_store) begin
        r_last      <= i_rand_word;
        r_have_last <= 1'b1;
      end
      if (w_accept & w_dup) o_stuck_err <= 1'b1;
    end
`else
  assign w_dup       = 1'b0;
  assign o_stuck_err = 1'b0;
`endif
  always_comb begin
    w_merged = r_shadow;
    w_merged[w_idx*N +: N] = i_rand_word;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= COLLECT;
    else r_state <= w_next;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_ready_q   <= 1'b0;
      r_shadow    <= '0;
      o_key_out   <= '0;
      o_key_valid <= 1'b0;
      o_word_cnt  <= '0;
      o_drop_cnt  <= '0;
    end else begin
      r_ready_q <= i_rand_ready;
      if (w_store) r_shadow <= w_merged;
      if (w_done) begin
        o_key_out   <= w_merged;
        o_key_valid <= 1'b1;
        o_word_cnt  <= '0;
      end else begin
        if (w_ack) o_key_valid <= 1'b0;
        if (w_store) o_word_cnt <= w_idx + 1'b1;
      end
      if ((r_state == HOLD) & w_accept & ~w_ack & (o_drop_cnt != 8'hFF))
        o_drop_cnt <= o_drop_cnt + 8'd1;
    end
endmodule

// File: tb/tb_chacha_key_assembler.sv
// tb_chacha_key_assembler: directed and random stimulus against a word-queue reference model.
module tb_chacha_key_assembler;
  localparam int N = 32, WORDS = 8, KW = N * WORDS;
`ifdef CHACHA_KEY_DEDUP_EN
  localparam bit DEDUP = 1'b1;
`else
  localparam bit DEDUP = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, rand_ready = 1'b0, key_ack = 1'b0;
  logic [N-1:0] rand_word = '0;
  logic [KW-1:0] key_out;
  logic key_valid, stuck_err;
  logic [3:0] word_cnt;
  logic [7:0] drop_cnt;
  int vectors = 0, miscompares = 0;
  logic [KW-1:0] exp_q[$];
  logic [N-1:0] m_words[$];
  logic [N-1:0] m_last;
  bit m_hold, m_have_last, m_stuck;
  int m_drop;

  always #5 clk = ~clk;

  chacha_key_assembler #(.N(N), .WORDS(WORDS)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rand_word(rand_word), .i_rand_ready(rand_ready),
    .i_key_ack(key_ack), .o_key_out(key_out), .o_key_valid(key_valid),
    .o_word_cnt(word_cnt), .o_drop_cnt(drop_cnt), .o_stuck_err(stuck_err)
  );

  task automatic chk(string name, logic [KW-1:0] act, logic [KW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: every new key presentation pops the scoreboard; held keys must not move
  logic prev_valid = 1'b0;
  logic [KW-1:0] held_key;
  always @(negedge clk) begin
    if (rst_n) begin
      if (key_valid && !prev_valid) begin
        if (exp_q.size() == 0) chk("unexpected_key", 1, 0);
        else chk("key_out", key_out, exp_q.pop_front());
        held_key = key_out;
      end else if (key_valid) chk("key_stable", key_out, held_key);
    end
    prev_valid = key_valid;
  end

  task automatic m_reset();
    m_words.delete();
    m_hold = 0; m_have_last = 0; m_stuck = 0; m_drop = 0; m_last = '0;
  endtask

  task automatic model_store(logic [N-1:0] w);
    m_words.push_back(w);
    m_last = w;
    m_have_last = 1;
  endtask

  task automatic model_accept(logic [N-1:0] w, bit ack);
    logic [KW-1:0] k;
    if (m_hold) begin
      if (ack) begin
        m_hold = 0;
        model_store(w);
      end else if (m_drop < 255) m_drop++;
    end else if (DEDUP && m_have_last && w == m_last) m_stuck = 1;
    else begin
      model_store(w);
      if (m_words.size() == WORDS) begin
        k = '0;
        foreach (m_words[i]) k[i*N +: N] = m_words[i];
        exp_q.push_back(k);
        m_words.delete();
        m_hold = 1;
      end
    end
  endtask

  task automatic pulse(logic [N-1:0] w, bit ack);
    @(negedge clk);
    rand_ready = 1; rand_word = w; key_ack = ack;
    model_accept(w, ack);
    @(negedge clk);
    rand_ready = 0; key_ack = 0;
  endtask

  task automatic ack_only();
    @(negedge clk);
    key_ack = 1;
    m_hold = 0;
    @(negedge clk);
    key_ack = 0;
  endtask

  task automatic held();
    logic [N-1:0] w;
    w = $urandom;
    @(negedge clk);
    rand_ready = 1; rand_word = w;
    model_accept(w, 0);
    repeat (19) begin
      @(negedge clk);
      rand_word = $urandom;
    end
    @(negedge clk);
    rand_ready = 0;
  endtask

  task automatic check_state(string tag);
    chk({tag, "_word_cnt"}, word_cnt, m_words.size());
    chk({tag, "_drop_cnt"}, drop_cnt, m_drop);
    chk({tag, "_stuck_err"}, stuck_err, m_stuck);
    chk({tag, "_key_valid"}, key_valid, m_hold);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 0;
    rand_ready = 0; key_ack = 0;
    m_reset();
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    check_state("reset");
    chk("reset_key_out", key_out, 0);
  endtask

  initial begin
    logic [N-1:0] a;
    m_reset();
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    check_state("por");
    chk("por_key_out", key_out, 0);
    for (int i = 1; i <= 8; i++) pulse(i * 32'h11111111, 0);
    check_state("t1");
    chk("t1_key", key_out,
        256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111);
    repeat (3) pulse($urandom, 0);
    check_state("t3_drop");
    chk("t3_drop3", drop_cnt, 3);
    ack_only();
    check_state("t3_ack");
    held();
    check_state("t2");
    chk("t2_cnt1", word_cnt, 1);
    repeat (7) pulse($urandom, 0);
    check_state("t4_pre");
    pulse(32'hDEADBEEF, 1);
    check_state("t4");
    chk("t4_cnt1", word_cnt, 1);
    repeat (7) pulse($urandom, 0);
    check_state("t4_key");
    ack_only();
    repeat (5) pulse($urandom, 0);
    do_reset();
    repeat (8) pulse($urandom, 0);
    check_state("t5");
    ack_only();
    do_reset();
    a = $urandom;
    pulse(a, 0);
    pulse(a, 0);
    pulse(a ^ 32'h1, 0);
    check_state("t6");
    chk("t6_cnt", word_cnt, DEDUP ? 2 : 3);
    chk("t6_stuck", stuck_err, DEDUP);
    while (!m_hold) pulse($urandom, 0);
    repeat (260) pulse($urandom, 0);
    check_state("sat");
    chk("sat_255", drop_cnt, 255);
    ack_only();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: pulse($urandom, m_hold && $urandom_range(0, 1) == 1);
        6: ack_only();
        7: repeat ($urandom_range(1, 3)) @(negedge clk);
        8: held();
        default: pulse(m_last, 0);
      endcase
      check_state("rnd");
    end
    repeat (2) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
